// File: rtl/uart_tx_serializer.sv
// Byte-wide UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// tx_start is sampled only in idle; tx_done pulses for one cycle when the last stop bit ends.
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned CntW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] BaudMax = CntW'(CLKS_PER_BIT - 1);
  localparam bit          ParEn   = (PARITY == 1) || (PARITY == 2);
  localparam logic        ParOdd  = (PARITY == 2);
  localparam int unsigned NStop   = (STOP_BITS == 2) ? 2 : 1;
  localparam logic [2:0]  LastStop = 3'(NStop - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            baud_tick;

  assign baud_tick = (baud_q == BaudMax);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q != StIdle) begin
      baud_d = baud_tick ? '0 : baud_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        baud_d = '0;
        bit_d  = '0;
        if (tx_start) begin
          shift_d = tx_data;
          par_d   = (^tx_data) ^ ParOdd;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_tick) begin
          state_d = StData;
          tx_d    = shift_q[0];
          bit_d   = '0;
        end
      end
      StData: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (ParEn) begin
              state_d = StParity;
              tx_d    = par_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            // Next bit is bit 1 of the pre-shift value, so tx stays registered.
            tx_d  = shift_q[1];
          end
        end
      end
      StParity: begin
        if (baud_tick) begin
          state_d = StStop;
          tx_d    = 1'b1;
          bit_d   = '0;
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          if (bit_q == LastStop) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four configurations (none/even/odd parity, two stop bits)
// checked cycle by cycle against a frame model built from bit positions.
module tb_uart_tx_serializer;

  localparam int Cpb = 4;

  logic       clk;
  logic       reset;
  logic [3:0] start;
  logic [7:0] data;
  logic [3:0] tx;
  logic [3:0] busy;
  logic [3:0] done;

  int n_checks;
  int n_fails;
  int done_cnt0;

  uart_tx_serializer #(.CLKS_PER_BIT(Cpb), .PARITY(0), .STOP_BITS(1)) u_none (
    .clk(clk), .reset(reset), .tx_start(start[0]), .tx_data(data),
    .tx(tx[0]), .busy(busy[0]), .tx_done(done[0])
  );
  uart_tx_serializer #(.CLKS_PER_BIT(Cpb), .PARITY(1), .STOP_BITS(1)) u_even (
    .clk(clk), .reset(reset), .tx_start(start[1]), .tx_data(data),
    .tx(tx[1]), .busy(busy[1]), .tx_done(done[1])
  );
  uart_tx_serializer #(.CLKS_PER_BIT(Cpb), .PARITY(2), .STOP_BITS(1)) u_odd (
    .clk(clk), .reset(reset), .tx_start(start[2]), .tx_data(data),
    .tx(tx[2]), .busy(busy[2]), .tx_done(done[2])
  );
  uart_tx_serializer #(.CLKS_PER_BIT(Cpb), .PARITY(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .reset(reset), .tx_start(start[3]), .tx_data(data),
    .tx(tx[3]), .busy(busy[3]), .tx_done(done[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done[0]) done_cnt0 <= done_cnt0 + 1;
  end

  function automatic int par_of(input int idx);
    return (idx == 1) ? 1 : (idx == 2) ? 2 : 0;
  endfunction

  function automatic int stop_of(input int idx);
    return (idx == 3) ? 2 : 1;
  endfunction

  function automatic int frame_bits(input int idx);
    return 1 + 8 + ((par_of(idx) != 0) ? 1 : 0) + stop_of(idx);
  endfunction

  // Expected line level for bit slot pos of a frame carrying b.
  function automatic logic exp_bit(input int idx, input logic [7:0] b, input int pos);
    int ones;
    ones = $countones(b);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (pos == 9 && par_of(idx) == 1) return logic'(ones % 2);
    if (pos == 9 && par_of(idx) == 2) return logic'(1 - (ones % 2));
    return 1'b1;
  endfunction

  task automatic check(input string tag, input int idx, input int k,
                       input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s dut%0d cycle %0d: observed %0h expected %0h", tag, idx, k, obs, expv);
    end
  endtask

  task automatic check_idle(input int idx, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check("idle_tx", idx, i, 8'(tx[idx]), 8'd1);
      check("idle_busy", idx, i, 8'(busy[idx]), 8'd0);
      check("idle_done", idx, i, 8'(done[idx]), 8'd0);
    end
  endtask

  // Sends b on dut idx and checks every cycle through the tx_done cycle.
  // hold keeps tx_start high so nxt is accepted right after tx_done; poke
  // raises tx_start mid-frame, which must be ignored.
  task automatic run_frame(input int idx, input logic [7:0] b, input bit hold,
                           input logic [7:0] nxt, input bit poke);
    int n;
    logic [7:0] dec;
    n = frame_bits(idx) * Cpb;
    dec = '0;
    start[idx] = 1'b1;
    data = b;
    @(posedge clk); #1;
    if (!hold) start[idx] = 1'b0;
    data = hold ? nxt : 8'($urandom);
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (poke && k == 10) start[idx] = 1'b1;
      if (poke && k == 11 && !hold) start[idx] = 1'b0;
      if (k < n) begin
        check("tx", idx, k, 8'(tx[idx]), 8'(exp_bit(idx, b, k / Cpb)));
        check("busy", idx, k, 8'(busy[idx]), 8'd1);
        check("done", idx, k, 8'(done[idx]), 8'd0);
        if (k / Cpb >= 1 && k / Cpb <= 8 && k % Cpb == Cpb / 2) dec[k/Cpb-1] = tx[idx];
      end else begin
        check("end_tx", idx, k, 8'(tx[idx]), 8'd1);
        check("end_busy", idx, k, 8'(busy[idx]), 8'd0);
        check("end_done", idx, k, 8'(done[idx]), 8'd1);
      end
    end
    check("decoded", idx, n, dec, b);
  endtask

  initial begin
    int base;
    n_checks  = 0;
    n_fails   = 0;
    done_cnt0 = 0;
    reset = 1'b1;
    start = '0;
    data  = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rst_tx", i, 0, 8'(tx[i]), 8'd1);
      check("rst_busy", i, 0, 8'(busy[i]), 8'd0);
      check("rst_done", i, 0, 8'(done[i]), 8'd0);
    end
    reset = 1'b0;
    check_idle(0, 2);

    // Single byte, with an ignored mid-frame request.
    run_frame(0, 8'hA5, 1'b0, 8'h00, 1'b1);
    check_idle(0, 3);

    // Parity and two stop bits.
    run_frame(1, 8'hA5, 1'b0, 8'h00, 1'b0);
    check_idle(1, 2);
    run_frame(2, 8'hA5, 1'b0, 8'h00, 1'b0);
    check_idle(2, 2);
    run_frame(1, 8'h01, 1'b0, 8'h00, 1'b0);
    check_idle(1, 2);
    run_frame(3, 8'hFF, 1'b0, 8'h00, 1'b0);
    check_idle(3, 2);

    // Back-to-back with tx_start held high.
    run_frame(0, 8'h00, 1'b1, 8'h55, 1'b1);
    run_frame(0, 8'h55, 1'b0, 8'h00, 1'b0);
    check_idle(0, 3);

    // Reset during data bit 3.
    start[0] = 1'b1;
    data = 8'h00;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check("mid_tx", 0, 16, 8'(tx[0]), 8'd0);
    check("mid_busy", 0, 16, 8'(busy[0]), 8'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_tx", 0, 0, 8'(tx[0]), 8'd1);
    check("abort_busy", 0, 0, 8'(busy[0]), 8'd0);
    check("abort_done", 0, 0, 8'(done[0]), 8'd0);
    check_idle(0, 40);
    run_frame(0, 8'h3C, 1'b0, 8'h00, 1'b0);
    check_idle(0, 2);

    // Sequencer handshake: pulse, wait for tx_done, next byte.
    base = done_cnt0;
    for (int i = 0; i < 8; i++) begin
      run_frame(0, 8'(i), 1'b0, 8'h00, 1'b0);
    end
    check_idle(0, 2);
    check("done_count", 0, 0, 8'(done_cnt0 - base), 8'd8);

    // Random bytes across all configurations.
    for (int r = 0; r < 12; r++) begin
      int idx;
      idx = int'($urandom_range(0, 3));
      run_frame(idx, 8'($urandom), 1'b0, 8'h00, ($urandom_range(0, 1) == 1));
      check_idle(idx, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
